// File: rtl/mcp_main_control_fsm.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/write-back.
// Control outputs are registered alongside the state so they never glitch on opcode.
module mcp_main_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       bad_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_IDLE   = 4'd15
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_e state_q, state_d;
    logic   bad_op_q, bad_op_d;
    ctrl_t  ctrl_q, ctrl_d;

    function automatic ctrl_t decode_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d  = state_q;
        bad_op_d = bad_op_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d  = S_FETCH;
                        bad_op_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                      state_d = S_FETCH;
            // Codes 12-14 only appear after an upset; park in IDLE.
            default:  state_d = S_IDLE;
        endcase
        ctrl_d = decode_ctrl(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bad_op_q <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            bad_op_q <= bad_op_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign pc_write      = ctrl_q.pc_write;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign ir_write      = ctrl_q.ir_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_dst       = ctrl_q.reg_dst;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign pc_source     = ctrl_q.pc_source;
    assign state         = state_q;
    assign bad_op        = bad_op_q;

endmodule

// File: tb/tb_mcp_main_control_fsm.sv
// Self-checking bench for mcp_main_control_fsm: expected state/control/bad_op per cycle
// are queued when an opcode is applied and compared as the FSM steps.
module tb_mcp_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       bad_op;

    int tests_run = 0;
    int tests_failed = 0;
    logic bad_model = 1'b0;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        bad;
    } exp_t;

    exp_t sb[$];

    mcp_main_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    // Order: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
    function automatic logic [15:0] act_ctrl();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    endfunction

    function automatic logic [15:0] exp_ctrl(input logic [3:0] s);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            4'd0:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            4'd9:  begin asa = 1; asb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [3:0] st, input logic bad);
        tests_run++;
        if (state !== st) begin
            tests_failed++;
            $display("FAIL %s state: got %0d expected %0d", name, state, st);
        end
        tests_run++;
        if (act_ctrl() !== exp_ctrl(st)) begin
            tests_failed++;
            $display("FAIL %s ctrl (state %0d): got %b expected %b", name, st, act_ctrl(), exp_ctrl(st));
        end
        tests_run++;
        if (bad_op !== bad) begin
            tests_failed++;
            $display("FAIL %s bad_op: got %b expected %b", name, bad_op, bad);
        end
    endtask

    // seq holds the expected states after FETCH, first state in the lowest nibble.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [23:0] seq,
                             input int n, input logic illegal);
        exp_t e;
        opcode = op;
        for (int i = 0; i < n; i++) begin
            if (illegal && i == 1) bad_model = 1'b1;
            e.st   = seq[4*i +: 4];
            e.ctrl = exp_ctrl(e.st);
            e.bad  = bad_model;
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            step();
            e = sb.pop_front();
            tests_run++;
            if (state !== e.st) begin
                tests_failed++;
                $display("FAIL %s step%0d state: got %0d expected %0d", name, i, state, e.st);
            end
            tests_run++;
            if (act_ctrl() !== e.ctrl) begin
                tests_failed++;
                $display("FAIL %s step%0d ctrl: got %b expected %b", name, i, act_ctrl(), e.ctrl);
            end
            tests_run++;
            if (bad_op !== e.bad) begin
                tests_failed++;
                $display("FAIL %s step%0d bad_op: got %b expected %b", name, i, bad_op, e.bad);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        opcode = 6'b100011;
        #1;
        check_now("reset_async", 4'd15, 1'b0);
        step();
        step();
        check_now("reset_held", 4'd15, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_now("reset_release_fetch", 4'd0, 1'b0);
    endtask

    task automatic test_lw();     run_instr("lw",    6'b100011, 24'h004321, 5, 1'b0); endtask
    task automatic test_sw();     run_instr("sw",    6'b101011, 24'h000521, 4, 1'b0); endtask
    task automatic test_rtype();  run_instr("rtype", 6'b000000, 24'h000761, 4, 1'b0); endtask
    task automatic test_addi();   run_instr("addi",  6'b001000, 24'h000A91, 4, 1'b0); endtask
    task automatic test_beq();    run_instr("beq",   6'b000100, 24'h000081, 3, 1'b0); endtask
    task automatic test_jump();   run_instr("j",     6'b000010, 24'h0000B1, 3, 1'b0); endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b111111, 24'h000001, 2, 1'b1);
        run_instr("sticky_after_illegal", 6'b000010, 24'h0000B1, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_sw",   6'b101011, 24'h000521, 4, 1'b0);
        run_instr("b2b_lw",   6'b100011, 24'h004321, 5, 1'b0);
        run_instr("b2b_beq",  6'b000100, 24'h000081, 3, 1'b0);
        run_instr("b2b_addi", 6'b001000, 24'h000A91, 4, 1'b0);
    endtask

    task automatic test_mid_reset();
        run_instr("lw_partial", 6'b100011, 24'h000321, 3, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        bad_model = 1'b0;
        check_now("mid_memrd_reset", 4'd15, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_now("post_reset_fetch", 4'd0, 1'b0);
        run_instr("post_reset_beq", 6'b000100, 24'h000081, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_addi();
        test_beq();
        test_jump();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
